dmem_io_responder: RTL and testbench
====================================

# dmem_io_responder

Memory-mapped I/O responder on the processor's data-memory port. Sits between the processor's dmem outputs and the dmem syncram. Decodes a small I/O window at the top of the 12-bit data address space, passes every other access through to dmem unchanged, and serves I/O accesses itself. The I/O window holds:

- a TX byte FIFO, drained by a valid/ready byte stream;
- an RX byte FIFO, filled by a valid/ready byte stream;
- a status register;
- a free-running cycle counter.

## Interface

Parameters:
- IO_BASE, 12'hFF0 — first word address of the 16-word I/O window (IO_BASE[3:0] must be 0).
- DEPTH, 8 — entries per FIFO; power of two, 2..8.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_address  in  12  processor data address.
- cpu_wdata  in  32  processor store data.
- cpu_wren  in  1  processor store strobe.
- cpu_rden  in  1  processor load strobe; only gates read side effects.
- cpu_rdata  out  32  load data returned to the processor (q_dmem side).
- mem_address  out  12  to dmem; equals cpu_address.
- mem_wdata  out  32  to dmem; equals cpu_wdata.
- mem_wren  out  1  to dmem; cpu_wren & ~io_hit.
- mem_q  in  32  dmem read data.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  consumer accepts tx_data.
- rx_valid  in  1  producer offers rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  RX FIFO can accept.

## Operation

- io_hit = (cpu_address[11:4] == IO_BASE[11:4]); offset = cpu_address[3:0].
- cpu_rdata is combinational:
  - io_hit = 0: mem_q.
  - io_hit = 1: the I/O register value below.
- Register map:
  - +0 TXDATA
    - Write: push cpu_wdata[7:0].
    - If full with no TX pop this cycle, the byte is dropped and tx_overflow is set.
    - Read: 0.
  - +1 RXDATA
    - Read returns {24'b0, RX head}, or 0 if empty.
    - Read with cpu_rden pops the head.
    - Read with cpu_rden while empty sets rx_underflow instead.
    - Write: ignored.
  - +2 STATUS
    - Read: bits [3:0] tx_count, [7:4] rx_count, [8] tx_full, [9] rx_empty, [10] tx_overflow, [11] rx_underflow, others 0.
    - Write: a 1 in bit 10 or 11 clears that sticky bit.
  - +3 CYCLES
    - Read: 32-bit counter; increments every non-reset cycle, wraps FFFFFFFF -> 0.
    - Write: ignored.
  - +4..+15: read 0, writes ignored.
- cpu_wren and cpu_rden asserted together:
  - the write is performed;
  - read side effects (RX pop, underflow) are suppressed.
- TX stream:
  - tx_valid = (tx_count != 0); tx_data = head.
  - Pop on a cycle with tx_valid & tx_ready.
  - Push and pop in the same cycle are both honoured, including when full: count unchanged, no overflow.
- RX stream:
  - rx_ready = (rx_count != DEPTH) & ~reset.
  - Push on rx_valid & rx_ready.
  - Push and pop in the same cycle are both honoured.
  - A pop while empty is an underflow even if a push occurs the same cycle; the pushed byte is stored and rx_count becomes 1.
- FIFOs are circular: read/write pointers wrap modulo DEPTH, and count is tracked separately (0..DEPTH).

## Timing

- Reset (sampled at posedge while reset = 1):
  - pointers, counts, sticky bits and CYCLES go to 0;
  - tx_valid = 0;
  - rx_ready = 0 while reset is high and 1 on the first cycle after.
- Reset mid-operation discards all FIFO contents. A byte presented on tx during a reset cycle is considered not transferred.
- Load latency:
  - Pass-through loads: cpu_rdata carries the same mem_q timing as a direct dmem connection; the block adds no registers.
  - I/O loads: data is valid in the same cycle as cpu_address; no wait states.
- Side effects (push, pop, sticky set/clear) commit at the rising edge ending the access cycle. A read of STATUS in the following cycle reflects them.
- CYCLES read in cycle N returns N, where the first cycle after reset is 0.
- Sticky set and software clear of the same bit in one cycle: set wins.
- TX byte latency: a TXDATA store in cycle N gives tx_valid = 1 in cycle N+1 if the FIFO was empty.

## Test plan

- Reset then idle:
  - tx_valid = 0, rx_ready = 1, STATUS = 0x200;
  - CYCLES read at cycle 5 returns 5.
- Pass-through:
  - store 0x12345678 to 0x010 -> mem_wren = 1;
  - load 0x010 -> cpu_rdata = mem_q;
  - store to 0xFF0 -> mem_wren = 0.
- TX path, tx_ready held 0:
  - store 0x41..0x49 (9 bytes) to TXDATA -> tx_count = 8, tx_full = 1, tx_overflow = 1;
  - raise tx_ready -> bytes 0x41..0x48 emerge in order, one per cycle;
  - write 0x400 to STATUS -> tx_overflow cleared.
- RX path:
  - push 0xA5, 0x5A -> RXDATA reads return 0xA5 then 0x5A;
  - third read -> 0 and rx_underflow = 1;
  - fill 8 bytes -> rx_ready = 0.
- Simultaneous events:
  - TX full with tx_ready = 1 and a TXDATA store in the same cycle -> count stays 8, no overflow;
  - empty RX with pop and push in the same cycle -> rx_underflow = 1, rx_count = 1.
- Reset mid-stream:
  - assert reset with 5 TX bytes queued -> next cycle tx_valid = 0, counts 0, CYCLES restarts at 0.

Source files
------------

// File: rtl/dmem_io_responder.sv
// Memory-mapped I/O responder on the dmem port: TX/RX byte FIFOs, status register, cycle counter in a 16-word window.
// Latency: loads are combinational (pass-through or I/O register); stores and pops commit on the closing clock edge.
// Backpressure: tx_valid/tx_ready drains TX, rx_ready deasserts when RX is full; a full TX drops the store and flags overflow.
module dmem_io_responder #(
  parameter logic [11:0] IO_BASE = 12'hFF0,
  parameter int          DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wren,
  input  logic        cpu_rden,
  output logic [31:0] cpu_rdata,
  output logic [11:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready
);

  // Pointer width indexes DEPTH entries; count width must also hold DEPTH itself.
  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [3:0] OFF_TXDATA = 4'd0;
  localparam logic [3:0] OFF_RXDATA = 4'd1;
  localparam logic [3:0] OFF_STATUS = 4'd2;
  localparam logic [3:0] OFF_CYCLES = 4'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];

  logic [PW-1:0] tx_rd_q, tx_rd_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [PW-1:0] rx_rd_q, rx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic [31:0]   cycles_q, cycles_d;

  // ---------------------------------------------------------------------------
  // Address decode and bus qualifiers
  // ---------------------------------------------------------------------------
  logic       io_hit;
  logic [3:0] offset;
  logic       io_wr;
  logic       io_rd;

  assign io_hit = (cpu_address[11:4] == IO_BASE[11:4]);
  assign offset = cpu_address[3:0];
  assign io_wr  = cpu_wren & io_hit;
  // A simultaneous store wins: read side effects only happen on pure loads.
  assign io_rd  = cpu_rden & ~cpu_wren & io_hit;

  // dmem sees every access, but never a store that landed in the I/O window.
  assign mem_address = cpu_address;
  assign mem_wdata   = cpu_wdata;
  assign mem_wren    = cpu_wren & ~io_hit;

  // ---------------------------------------------------------------------------
  // FIFO handshakes
  // ---------------------------------------------------------------------------
  logic tx_full;
  logic tx_empty;
  logic rx_full;
  logic rx_empty;
  logic tx_pop;
  logic tx_push_req;
  logic tx_push;
  logic rx_push;
  logic rx_pop_req;
  logic rx_pop;
  logic status_wr;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem_q[tx_rd_q];
  assign rx_ready = ~rx_full & ~reset;

  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = io_wr & (offset == OFF_TXDATA);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  assign rx_push    = rx_valid & rx_ready;
  assign rx_pop_req = io_rd & (offset == OFF_RXDATA);
  // Emptiness is judged before this cycle's push, so pop+push on empty is an underflow.
  assign rx_pop     = rx_pop_req & ~rx_empty;

  assign status_wr = io_wr & (offset == OFF_STATUS);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] status_w;
  logic [31:0] io_rdata;

  // Assemble STATUS from live counts and sticky flags.
  always_comb begin
    status_w       = '0;
    status_w[3:0]  = 4'(tx_cnt_q);
    status_w[7:4]  = 4'(rx_cnt_q);
    status_w[8]    = tx_full;
    status_w[9]    = rx_empty;
    status_w[10]   = tx_ovf_q;
    status_w[11]   = rx_udf_q;
  end

  // Select the I/O register for the current offset, then pick I/O vs dmem data.
  always_comb begin
    io_rdata = '0;
    case (offset)
      OFF_RXDATA: io_rdata = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rd_q]};
      OFF_STATUS: io_rdata = status_w;
      OFF_CYCLES: io_rdata = cycles_q;
      default:    io_rdata = '0;
    endcase
    cpu_rdata = io_hit ? io_rdata : mem_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Advance pointers and counts for whichever of push/pop happen this cycle.
  always_comb begin
    tx_rd_d  = tx_rd_q;
    tx_wr_d  = tx_wr_q;
    tx_cnt_d = tx_cnt_q;
    rx_rd_d  = rx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_cnt_d = rx_cnt_q;

    if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
    if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase

    if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
    if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Sticky error flags: software clear first, so a same-cycle set overrides it.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (status_wr && cpu_wdata[10]) tx_ovf_d = 1'b0;
    if (status_wr && cpu_wdata[11]) rx_udf_d = 1'b0;
    if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_pop_req && rx_empty) rx_udf_d = 1'b1;
    cycles_d = cycles_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control state with synchronous reset; reset discards queued bytes by zeroing counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      cycles_q <= '0;
    end else begin
      tx_rd_q  <= tx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_cnt_q <= tx_cnt_d;
      rx_rd_q  <= rx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      cycles_q <= cycles_d;
    end
  end

  // FIFO storage needs no reset; writes are blocked during reset so no stale byte lands.
  always_ff @(posedge clock) begin
    if (!reset && tx_push) tx_mem_q[tx_wr_q] <= cpu_wdata[7:0];
    if (rx_push)           rx_mem_q[rx_wr_q] <= rx_data;
  end

endmodule

// File: tb/tb_dmem_io_responder.sv
module tb_dmem_io_responder;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [11:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [31:0] cpu_rdata;
  logic [11:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  int n_cmp = 0;
  int n_err = 0;

  dmem_io_responder #(.IO_BASE(12'hFF0), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_wren(cpu_wren), .cpu_rden(cpu_rden), .cpu_rdata(cpu_rdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: byte queues, sticky flags and a cycle number.
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic [31:0] m_cycles = 32'd0;

  function automatic logic [31:0] exp_status();
    logic [31:0] st;
    st = 32'd0;
    st[3:0] = 4'(tx_q.size());
    st[7:4] = 4'(rx_q.size());
    st[8]   = (tx_q.size() == DEPTH);
    st[9]   = (rx_q.size() == 0);
    st[10]  = m_ovf;
    st[11]  = m_udf;
    return st;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (cpu_address[11:4] != 8'hFF) return mem_q;
    case (cpu_address[3:0])
      4'd1:    return (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
      4'd2:    return exp_status();
      4'd3:    return m_cycles;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge's worth of behaviour from the current inputs.
  task automatic model_step();
    logic hit, wr, rd, t_pop, t_push, r_push, r_rd;
    logic [3:0] off;
    int txn, rxn;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_cycles = 32'd0;
      return;
    end
    hit = (cpu_address[11:4] == 8'hFF);
    off = cpu_address[3:0];
    wr  = cpu_wren && hit;
    rd  = cpu_rden && !cpu_wren && hit;
    txn = tx_q.size();
    rxn = rx_q.size();
    t_pop  = (txn != 0) && tx_ready;
    t_push = wr && (off == 4'd0);
    r_push = rx_valid && (rxn < DEPTH);
    r_rd   = rd && (off == 4'd1);
    if (wr && off == 4'd2 && cpu_wdata[10]) m_ovf = 1'b0;
    if (wr && off == 4'd2 && cpu_wdata[11]) m_udf = 1'b0;
    if (t_push && txn == DEPTH && !t_pop) m_ovf = 1'b1;
    if (r_rd && rxn == 0) m_udf = 1'b1;
    if (t_pop) void'(tx_q.pop_front());
    if (t_push && (txn < DEPTH || t_pop)) tx_q.push_back(cpu_wdata[7:0]);
    if (r_rd && rxn != 0) void'(rx_q.pop_front());
    if (r_push) rx_q.push_back(rx_data);
    m_cycles = m_cycles + 32'd1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    cpu_address = 12'h000;
    cpu_wdata   = 32'd0;
    cpu_wren    = 1'b0;
    cpu_rden    = 1'b0;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'd0;
    mem_q       = $urandom;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    set_idle();
    cpu_address = a;
    cpu_wdata   = d;
    cpu_wren    = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    #1;
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rst_rx_ready_hi: got %b want 0", rx_ready); end
    tick();
    tick();
    reset = 1'b0;
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
    n_cmp++; if (cpu_rdata !== 32'h200) begin n_err++; $display("FAIL rst_status: got %h want 00000200", cpu_rdata); end
    tick();
    set_idle();
    repeat (4) tick();
    cpu_address = 12'hFF3;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'd5) begin n_err++; $display("FAIL cycles_at_5: got %0d want 5", cpu_rdata); end
    tick();
  endtask

  task automatic test_passthrough();
    logic [31:0] q;
    do_reset();
    cpu_address = 12'h010;
    cpu_wdata = 32'h12345678;
    cpu_wren = 1'b1;
    #1;
    n_cmp++; if (mem_wren !== 1'b1) begin n_err++; $display("FAIL pt_store_wren: got %b want 1", mem_wren); end
    n_cmp++; if (mem_address !== 12'h010 || mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL pt_store_bus: got %h/%h want 010/12345678", mem_address, mem_wdata); end
    tick();
    set_idle();
    q = $urandom;
    mem_q = q;
    cpu_address = 12'h010;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== q) begin n_err++; $display("FAIL pt_load: got %h want %h", cpu_rdata, q); end
    tick();
    set_idle();
    cpu_address = 12'hFF0;
    cpu_wdata = 32'h77;
    cpu_wren = 1'b1;
    #1;
    n_cmp++; if (mem_wren !== 1'b0) begin n_err++; $display("FAIL pt_io_wren: got %b want 0", mem_wren); end
    tick();
  endtask

  task automatic test_tx();
    do_reset();
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_pre_valid: got %b want 0", tx_valid); end
    for (int i = 0; i < 9; i++) begin
      store(12'hFF0, 32'h41 + i);
      if (i == 0) begin
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_latency: got %b want 1", tx_valid); end
      end
    end
    set_idle();
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h708) begin n_err++; $display("FAIL tx_full_status: got %h want 00000708", cpu_rdata); end
    tick();
    set_idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin n_err++; $display("FAIL tx_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
    store(12'hFF2, 32'h400);
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h200) begin n_err++; $display("FAIL tx_ovf_clear: got %h want 00000200", cpu_rdata); end
    tick();
  endtask

  task automatic test_rx();
    logic [7:0] want [3];
    want[0] = 8'hA5; want[1] = 8'h5A; want[2] = 8'h00;
    do_reset();
    rx_valid = 1'b1; rx_data = 8'hA5; tick();
    rx_data = 8'h5A; tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      cpu_address = 12'hFF1;
      cpu_rden = 1'b1;
      #1;
      n_cmp++; if (cpu_rdata !== {24'd0, want[i]}) begin n_err++; $display("FAIL rx_read_%0d: got %h want %h", i, cpu_rdata, want[i]); end
      tick();
    end
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'hA00) begin n_err++; $display("FAIL rx_underflow: got %h want 00000A00", cpu_rdata); end
    tick();
    store(12'hFF2, 32'h800);
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(8'h10 + i);
      #1;
      if (i < 8) begin
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_fill_rdy_%0d: got %b want 1", i, rx_ready); end
      end else begin
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_full_rdy: got %b want 0", rx_ready); end
      end
      tick();
    end
    set_idle();
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h080) begin n_err++; $display("FAIL rx_full_status: got %h want 00000080", cpu_rdata); end
    tick();
    for (int i = 0; i < 8; i++) begin
      cpu_address = 12'hFF1;
      cpu_rden = 1'b1;
      #1;
      n_cmp++; if (cpu_rdata !== 32'(8'h10 + i)) begin n_err++; $display("FAIL rx_drain_%0d: got %h want %h", i, cpu_rdata, 32'(8'h10 + i)); end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 8; i++) store(12'hFF0, 32'h60 + i);
    set_idle();
    cpu_address = 12'hFF0;
    cpu_wdata = 32'h99;
    cpu_wren = 1'b1;
    tx_ready = 1'b1;
    #1;
    n_cmp++; if (tx_data !== 8'h60) begin n_err++; $display("FAIL sim_tx_head: got %h want 60", tx_data); end
    tick();
    set_idle();
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h308) begin n_err++; $display("FAIL sim_tx_status: got %h want 00000308", cpu_rdata); end
    tick();
    set_idle();
    rx_valid = 1'b1;
    rx_data = 8'h33;
    cpu_address = 12'hFF1;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_err++; $display("FAIL sim_rx_empty_read: got %h want 0", cpu_rdata); end
    tick();
    set_idle();
    cpu_address = 12'hFF2;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h918) begin n_err++; $display("FAIL sim_rx_status: got %h want 00000918", cpu_rdata); end
    tick();
    set_idle();
    cpu_address = 12'hFF1;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h33) begin n_err++; $display("FAIL sim_rx_byte: got %h want 33", cpu_rdata); end
    tick();
    set_idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (tx_data !== ((i < 7) ? 8'(8'h61 + i) : 8'h99)) begin n_err++; $display("FAIL sim_tx_order_%0d: got %h", i, tx_data); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) store(12'hFF0, 32'hC0 + i);
    set_idle();
    reset = 1'b1;
    tx_ready = 1'b1;
    tick();
    reset = 1'b0;
    cpu_address = 12'hFF3;
    cpu_rden = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_err++; $display("FAIL mid_cycles: got %0d want 0", cpu_rdata); end
    tick();
    cpu_address = 12'hFF2;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h200) begin n_err++; $display("FAIL mid_status: got %h want 00000200", cpu_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] er;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_idle();
      reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) cpu_address = 12'($urandom_range(0, 12'hFEF));
      else cpu_address = 12'hFF0 | 12'($urandom_range(0, 4));
      cpu_wdata = $urandom;
      if ($urandom_range(0, 1) == 0) cpu_wdata[11:10] = 2'b00;
      cpu_wren = ($urandom_range(0, 2) == 0);
      cpu_rden = ($urandom_range(0, 1) == 0);
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 1) == 0);
      rx_data  = 8'($urandom);
      #1;
      er = exp_rdata();
      n_cmp++; if (cpu_rdata !== er) begin n_err++; $display("FAIL rnd_rdata c=%0d a=%h: got %h want %h", c, cpu_address, cpu_rdata, er); end
      n_cmp++; if (mem_wren !== (cpu_wren && cpu_address[11:4] != 8'hFF)) begin n_err++; $display("FAIL rnd_mem_wren c=%0d: got %b", c, mem_wren); end
      n_cmp++; if (mem_address !== cpu_address || mem_wdata !== cpu_wdata) begin n_err++; $display("FAIL rnd_mem_bus c=%0d: got %h/%h", c, mem_address, mem_wdata); end
      n_cmp++; if (tx_valid !== (tx_q.size() != 0)) begin n_err++; $display("FAIL rnd_tx_valid c=%0d: got %b want %b", c, tx_valid, tx_q.size() != 0); end
      n_cmp++; if (rx_ready !== (rx_q.size() < DEPTH && !reset)) begin n_err++; $display("FAIL rnd_rx_ready c=%0d: got %b", c, rx_ready); end
      if (tx_q.size() != 0) begin
        n_cmp++; if (tx_data !== tx_q[0]) begin n_err++; $display("FAIL rnd_tx_data c=%0d: got %h want %h", c, tx_data, tx_q[0]); end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_tx();
    test_rx();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
